// File: rtl/riscv_pkg.sv
// Shared RV32I encodings used by the writeback stage and its load formatter.
package riscv_pkg;
  localparam int XLEN = 32;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_LOAD = 2'd1;
  localparam logic [1:0] WB_PC4  = 2'd2;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef struct packed {
    logic            valid;
    logic [4:0]      rd;
    logic            rf_we;
    logic [1:0]      wb_sel;
    logic [2:0]      funct3;
    logic [XLEN-1:0] alu;
    logic [XLEN-1:0] pc;
  } wb_reg_t;
endpackage

// File: rtl/load_align.sv
// Picks the byte/halfword lane of a load word and sign/zero-extends it.
module load_align
  import riscv_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      addr,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);
  logic [3:0][7:0] lanes;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  assign lanes    = word;
  assign byte_sel = lanes[addr];
  assign half_sel = addr[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data = word;
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = word;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// MEM/WB pipeline register, load formatting, register-file write port,
// bypass copy and retired-instruction counter.
module wb_stage
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [4:0]  rd_in,
  input  logic        rf_we_in,
  input  logic [1:0]  wb_sel_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] alu_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] dmem_rdata,
  output logic [4:0]  WAddr_RF,
  output logic        WrEn_RF,
  output logic [31:0] WD_RF,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [31:0] instret
);
  wb_reg_t     q;
  logic        first_q;
  logic [31:0] hold_q;
  logic [31:0] fmt_data;
  logic [31:0] load_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      q       <= '{valid: 1'b0, rd: 5'd0, rf_we: 1'b0, wb_sel: WB_ALU,
                   funct3: 3'd0, alu: 32'd0, pc: RESET_PC};
      first_q <= 1'b0;
    end else if (stall) begin
      // dmem_rdata is only good for one cycle; after that hold_q carries it
      if (first_q) first_q <= 1'b0;
    end else if (flush) begin
      q.valid <= 1'b0;
      first_q <= 1'b0;
    end else begin
      q       <= '{valid: valid_in, rd: rd_in, rf_we: rf_we_in, wb_sel: wb_sel_in,
                   funct3: funct3_in, alu: alu_in, pc: pc_in};
      first_q <= 1'b1;
    end
  end

  load_align u_align (
    .word   (dmem_rdata),
    .addr   (q.alu[1:0]),
    .funct3 (q.funct3),
    .data   (fmt_data)
  );

  always_ff @(posedge clk) begin
    if (rst)          hold_q <= 32'd0;
    else if (first_q) hold_q <= fmt_data;
  end

  assign load_val = first_q ? fmt_data : hold_q;

  always_comb begin
    WD_RF = q.alu;
    case (q.wb_sel)
      WB_LOAD: WD_RF = load_val;
      WB_PC4:  WD_RF = q.pc + 32'd4;
      default: WD_RF = q.alu;
    endcase
  end

  assign WAddr_RF = q.rd;
  assign WrEn_RF  = q.valid & q.rf_we & (q.rd != 5'd0);

  assign fwd_valid = WrEn_RF;
  assign fwd_rd    = WAddr_RF;
  assign fwd_data  = WD_RF;

  // Counts on departure so a stalled instruction is counted exactly once
  always_ff @(posedge clk) begin
    if (rst)                   instret <= 32'd0;
    else if (q.valid && !stall) instret <= instret + 32'd1;
  end
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: reset, ALU/load/PC4 writeback, stall, flush.
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        rst, stall, flush, valid_in, rf_we_in;
  logic [4:0]  rd_in;
  logic [1:0]  wb_sel_in;
  logic [2:0]  funct3_in;
  logic [31:0] alu_in, pc_in, dmem_rdata;
  logic [4:0]  WAddr_RF, fwd_rd;
  logic        WrEn_RF, fwd_valid;
  logic [31:0] WD_RF, fwd_data, instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .valid_in(valid_in),
    .rd_in(rd_in), .rf_we_in(rf_we_in), .wb_sel_in(wb_sel_in), .funct3_in(funct3_in),
    .alu_in(alu_in), .pc_in(pc_in), .dmem_rdata(dmem_rdata),
    .WAddr_RF(WAddr_RF), .WrEn_RF(WrEn_RF), .WD_RF(WD_RF),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic port(input string tag, input logic we, input logic [4:0] ad,
                      input logic [31:0] wd, input logic [31:0] ir);
    chk({tag, ".we"}, {31'd0, WrEn_RF}, {31'd0, we});
    chk({tag, ".addr"}, {27'd0, WAddr_RF}, {27'd0, ad});
    chk({tag, ".wd"}, WD_RF, wd);
    chk({tag, ".fwd_v"}, {31'd0, fwd_valid}, {31'd0, we});
    chk({tag, ".fwd_rd"}, {27'd0, fwd_rd}, {27'd0, ad});
    chk({tag, ".fwd_d"}, fwd_data, wd);
    chk({tag, ".instret"}, instret, ir);
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                       input logic [1:0] sel, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] pc);
    valid_in = v; rd_in = rd; rf_we_in = we; wb_sel_in = sel;
    funct3_in = f3; alu_in = alu; pc_in = pc;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; dmem_rdata = 32'h80FF_7F01;
    drive(1'b1, 5'd4, 1'b1, 2'd0, 3'd0, 32'h1111_2222, 32'h40);
    step(); step();
    port("reset", 1'b0, 5'd0, 32'd0, 32'd0);
    rst = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
    step(); step(); step();
    chk("idle.instret", instret, 32'd0);

    drive(1'b1, 5'd5, 1'b1, 2'd0, 3'd0, 32'h1234_5678, 32'h0);
    step(); port("alu_rd5", 1'b1, 5'd5, 32'h1234_5678, 32'd0);
    drive(1'b1, 5'd0, 1'b1, 2'd0, 3'd0, 32'h1234_5678, 32'h0);
    step(); port("alu_rd0", 1'b0, 5'd0, 32'h1234_5678, 32'd1);

    // Loads from word 80FF_7F01
    drive(1'b1, 5'd10, 1'b1, 2'd1, 3'd0, 32'h0000_1003, 32'h0);
    step(); port("lb_a3", 1'b1, 5'd10, 32'hFFFF_FF80, 32'd2);
    drive(1'b1, 5'd10, 1'b1, 2'd1, 3'd4, 32'h0000_1003, 32'h0);
    step(); port("lbu_a3", 1'b1, 5'd10, 32'h0000_0080, 32'd3);
    drive(1'b1, 5'd11, 1'b1, 2'd1, 3'd1, 32'h0000_1002, 32'h0);
    step(); port("lh_a2", 1'b1, 5'd11, 32'hFFFF_80FF, 32'd4);
    drive(1'b1, 5'd11, 1'b1, 2'd1, 3'd5, 32'h0000_1003, 32'h0);
    step(); port("lhu_a3", 1'b1, 5'd11, 32'h0000_80FF, 32'd5);
    drive(1'b1, 5'd12, 1'b1, 2'd1, 3'd2, 32'h0000_1001, 32'h0);
    step(); port("lw", 1'b1, 5'd12, 32'h80FF_7F01, 32'd6);
    drive(1'b1, 5'd12, 1'b1, 2'd1, 3'd3, 32'h0000_1000, 32'h0);
    step(); port("f3_ill", 1'b1, 5'd12, 32'h80FF_7F01, 32'd7);
    drive(1'b1, 5'd13, 1'b1, 2'd1, 3'd0, 32'h0000_1001, 32'h0);
    step(); port("lb_a1", 1'b1, 5'd13, 32'h0000_007F, 32'd8);

    // Load held across a 3-cycle stall while memory data goes away
    drive(1'b1, 5'd14, 1'b1, 2'd1, 3'd0, 32'h0000_2003, 32'h0);
    step(); port("st_c1", 1'b1, 5'd14, 32'hFFFF_FF80, 32'd9);
    stall = 1'b1;
    drive(1'b1, 5'd20, 1'b1, 2'd0, 3'd0, 32'h5555_5555, 32'h0);
    step(); dmem_rdata = 32'd0; #1;
    port("st_c2", 1'b1, 5'd14, 32'hFFFF_FF80, 32'd9);
    step(); port("st_c3", 1'b1, 5'd14, 32'hFFFF_FF80, 32'd9);
    step(); port("st_c4", 1'b1, 5'd14, 32'hFFFF_FF80, 32'd9);
    stall = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
    step(); port("st_leave", 1'b0, 5'd0, 32'd0, 32'd10);

    drive(1'b1, 5'd7, 1'b1, 2'd2, 3'd0, 32'h0, 32'hFFFF_FFFC);
    step(); port("pc4_wrap", 1'b1, 5'd7, 32'h0000_0000, 32'd10);
    drive(1'b1, 5'd7, 1'b1, 2'd2, 3'd0, 32'h0, 32'h0000_0100);
    step(); port("pc4", 1'b1, 5'd7, 32'h0000_0104, 32'd11);
    drive(1'b1, 5'd8, 1'b1, 2'd3, 3'd0, 32'hDEAD_BEEF, 32'h0000_0200);
    step(); port("sel3", 1'b1, 5'd8, 32'hDEAD_BEEF, 32'd12);

    flush = 1'b1;
    drive(1'b1, 5'd6, 1'b1, 2'd0, 3'd0, 32'h7777_0000, 32'h0);
    step(); chk("flush.we", {31'd0, WrEn_RF}, 32'd0); chk("flush.instret", instret, 32'd13);
    flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
    step(); chk("bubble.instret", instret, 32'd13);

    drive(1'b1, 5'd9, 1'b1, 2'd0, 3'd0, 32'hAAAA_5555, 32'h0);
    step(); port("pre_sf", 1'b1, 5'd9, 32'hAAAA_5555, 32'd13);
    stall = 1'b1; flush = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 2'd0, 3'd0, 32'h0, 32'h0);
    step(); port("stall_flush", 1'b1, 5'd9, 32'hAAAA_5555, 32'd13);
    step(); port("stall_flush2", 1'b1, 5'd9, 32'hAAAA_5555, 32'd13);
    rst = 1'b1;
    step(); port("rst_mid", 1'b0, 5'd0, 32'd0, 32'd0);
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    drive(1'b0, 5'd0, 1'b0, 2'd0, 3'd0, 32'd0, 32'd0);
    step(); port("post_rst", 1'b0, 5'd0, 32'd0, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
